// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing the write port of an async FIFO among NREQ
//   requesters in the wclk domain. One requester owns the port at a time for
//   a burst of at most MAXBURST words. A burst ends on the requester's last
//   word, on reaching MAXBURST, or when the requester drops req. Every burst
//   is followed by a fixed two-cycle bubble (RELEASE, then IDLE), and the
//   search for the next owner starts just past the previous owner.
//
// Ports
//   wclk      write-domain clock, rising edge
//   wrst      asynchronous active-high reset
//   req       per-requester request level
//   req_data  packed words, slice i belongs to requester i
//   req_last  current word of requester i is its last
//   wfull     FIFO full flag
//   gnt       registered one-hot grant
//   ack       word of the owner accepted this cycle (combinational)
//   winc      FIFO write enable (combinational)
//   wdata     FIFO write data, owner's slice of req_data
//   grant_id  index of current or most recent owner (registered)
//   busy      high while a grant is held (registered)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no owner; arbitrate among req at the next edge
// GRANT   | owner holds the write port; one word per cycle while !wfull
// RELEASE | one-cycle gap after a burst; always returns to IDLE
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 8,
  parameter int MAXBURST = 4
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATASIZE-1:0]  req_data,
  input  logic [NREQ-1:0]           req_last,
  input  logic                      wfull,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           ack,
  output logic                      winc,
  output logic [DATASIZE-1:0]       wdata,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = 4;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [IDW-1:0]  r_gid, w_gid_nxt;
  logic [IDW-1:0]  r_ptr, w_ptr_nxt;
  logic            r_busy, w_busy_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  logic [IDW-1:0]  w_sel;
  logic [IDW-1:0]  w_idx;
  logic            w_found;
  logic [IDW-1:0]  w_gid_inc;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_req_own;
  logic            w_last_own;
  logic            w_winc;

  // First requesting index at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gid == IDW'(i)) wdata = req_data[i*DATASIZE +: DATASIZE];
    end
  end

  assign w_req_own  = req[r_gid];
  assign w_last_own = req_last[r_gid];
  assign w_gid_inc  = (r_gid == IDW'(NREQ-1)) ? '0 : r_gid + IDW'(1);
  assign w_cnt_inc  = r_cnt + CW'(1);

  // Gated by wrst so nothing is written while reset is asserted.
  assign w_winc = (r_state == S_GRANT) & w_req_own & ~wfull & ~wrst;

  assign winc     = w_winc;
  assign ack      = w_winc ? (NREQ'(1) << r_gid) : '0;
  assign gnt      = r_gnt;
  assign grant_id = r_gid;
  assign busy     = r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_gid_nxt   = r_gid;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = NREQ'(1) << w_sel;
          w_gid_nxt   = w_sel;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_GRANT: begin
        // A withdrawn request releases even while stalled on wfull.
        if (!w_req_own ||
            (w_winc && (w_last_own || (w_cnt_inc == CW'(MAXBURST))))) begin
          w_state_nxt = S_RELEASE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = w_gid_inc;
        end else if (w_winc) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_gid   <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_gid   <= w_gid_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Requesters are modelled as queues of {last, data} words; a word leaves
//   its queue when acked. The expected write stream is computed up front by
//   a transaction-level round-robin model over those queues.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DS   = 8;
  localparam int MAXB = 4;
  localparam int IDW  = 2;

  logic                 wclk = 1'b0;
  logic                 wrst;
  logic [NREQ-1:0]      req;
  logic [NREQ*DS-1:0]   req_data;
  logic [NREQ-1:0]      req_last;
  logic                 wfull;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic                 winc;
  logic [DS-1:0]        wdata;
  logic [IDW-1:0]       grant_id;
  logic                 busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DATASIZE(DS), .MAXBURST(MAXB)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data),
    .req_last(req_last), .wfull(wfull), .gnt(gnt), .ack(ack),
    .winc(winc), .wdata(wdata), .grant_id(grant_id), .busy(busy)
  );

  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DS:0]      rq [NREQ][$];
  logic [IDW+DS-1:0] exp_q[$];
  int model_ptr;
  int force_full;
  bit rand_full;
  int wr_cnt;
  int full_after;

  logic [NREQ-1:0] gnt_log[$];
  logic [NREQ-1:0] ack_log[$];
  logic            winc_log[$];
  logic            busy_log[$];
  logic [IDW-1:0]  gid_log[$];

  int b_own[$];
  int b_len[$];
  int b_st[$];
  int b_en[$];
  int wr_idx[$];

  function automatic int owner_of(logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i] === 1'b1) r = i;
    return r;
  endfunction

  // Round-robin at transaction level: bursts end on last, MAXBURST, or an
  // empty queue; the next search starts just past the previous owner.
  function automatic void build_expected();
    logic [DS:0] cp [NREQ][$];
    logic [DS:0] w;
    int o;
    int n;
    for (int i = 0; i < NREQ; i++) cp[i] = rq[i];
    for (int g = 0; g < 1000; g++) begin
      o = -1;
      for (int k = 0; k < NREQ; k++)
        if (o < 0 && cp[(model_ptr + k) % NREQ].size() > 0) o = (model_ptr + k) % NREQ;
      if (o < 0) break;
      n = 0;
      do begin
        w = cp[o].pop_front();
        exp_q.push_back({IDW'(o), w[DS-1:0]});
        n++;
      end while (!w[DS] && n < MAXB && cp[o].size() > 0);
      model_ptr = (o + 1) % NREQ;
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req[i] = 1'b1;
        req_data[i*DS +: DS] = rq[i][0][DS-1:0];
        req_last[i] = rq[i][0][DS];
      end else begin
        req[i] = 1'b0;
        req_data[i*DS +: DS] = DS'($urandom);
        req_last[i] = 1'($urandom_range(0, 1));
      end
    end
    if (force_full > 0) begin
      wfull = 1'b1;
      force_full--;
    end else begin
      wfull = rand_full ? ($urandom_range(0, 9) < 3) : 1'b0;
    end
  endtask

  task automatic step();
    logic [IDW-1:0] own;
    logic [NREQ-1:0] acked;
    @(negedge wclk);
    gnt_log.push_back(gnt);
    ack_log.push_back(ack);
    winc_log.push_back(winc);
    busy_log.push_back(busy);
    gid_log.push_back(grant_id);
    n_cmp++;
    if (($countones(gnt) <= 1) !== 1'b1) begin
      n_err++; $display("FAIL gnt_onehot: gnt=%b required zero or one-hot", gnt);
    end
    n_cmp++;
    if ((ack & ~gnt) !== '0) begin
      n_err++; $display("FAIL ack_nonowner: ack=%b gnt=%b required ack within gnt", ack, gnt);
    end
    n_cmp++;
    if ((winc & ~busy) !== 1'b0) begin
      n_err++; $display("FAIL winc_busy: winc=%b busy=%b required winc implies busy", winc, busy);
    end
    n_cmp++;
    if ((winc & wfull) !== 1'b0) begin
      n_err++; $display("FAIL winc_wfull: winc=%b wfull=%b required no write when full", winc, wfull);
    end
    n_cmp++;
    if ($countones(ack) !== (winc === 1'b1 ? 1 : 0)) begin
      n_err++; $display("FAIL ack_count: ack=%b winc=%b required one ack per write", ack, winc);
    end
    if (winc === 1'b1) begin
      own = IDW'(owner_of(ack));
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL write_extra: got owner %0d data %h required no write", own, wdata);
      end else begin
        if ({own, wdata} !== exp_q[0]) begin
          n_err++;
          $display("FAIL write_word: got owner %0d data %h required owner %0d data %h",
                   own, wdata, exp_q[0][IDW+DS-1:DS], exp_q[0][DS-1:0]);
        end
        void'(exp_q.pop_front());
      end
      wr_cnt++;
      if (wr_cnt == full_after) force_full = 5;
    end
    acked = ack;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acked[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
    drive();
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) e = 1'b0;
    return e;
  endfunction

  task automatic run_until_done(input int budget, input string name);
    int c;
    c = 0;
    while (!(all_empty() && busy === 1'b0 && exp_q.size() == 0) && c < budget) begin
      step();
      c++;
    end
    n_cmp++;
    if (c >= budget) begin
      n_err++; $display("FAIL %s_timeout: %0d cycles used, %0d words outstanding, required completion", name, c, exp_q.size());
    end
    step();
    step();
  endtask

  task automatic begin_test();
    gnt_log.delete(); ack_log.delete(); winc_log.delete();
    busy_log.delete(); gid_log.delete();
    wr_cnt = 0; full_after = 0; rand_full = 1'b0; force_full = 0;
  endtask

  task automatic scan_bursts();
    int prev;
    b_own.delete(); b_len.delete(); b_st.delete(); b_en.delete(); wr_idx.delete();
    prev = -10;
    for (int k = 0; k < winc_log.size(); k++) begin
      if (winc_log[k] === 1'b1) begin
        wr_idx.push_back(k);
        if (k != prev + 1) begin
          b_own.push_back(owner_of(gnt_log[k]));
          b_len.push_back(1);
          b_st.push_back(k);
          b_en.push_back(k);
        end else begin
          b_len[b_len.size()-1] = b_len[b_len.size()-1] + 1;
          b_en[b_en.size()-1] = k;
        end
        prev = k;
      end
    end
  endtask

  task automatic apply_reset();
    wrst = 1'b1;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
    drive();
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL rst_gnt: got %b required 0", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_cmp++; if (grant_id !== '0) begin n_err++; $display("FAIL rst_gid: got %0d required 0", grant_id); end
    n_cmp++; if (winc !== 1'b0) begin n_err++; $display("FAIL rst_winc: got %b required 0", winc); end
    n_cmp++; if (ack !== '0) begin n_err++; $display("FAIL rst_ack: got %b required 0", ack); end
    req = '1; req_last = '1; req_data = {$urandom};
    @(posedge wclk); #1;
    @(posedge wclk); #1;
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL rst_req_gnt: got %b required 0", gnt); end
    n_cmp++; if (winc !== 1'b0) begin n_err++; $display("FAIL rst_req_winc: got %b required 0", winc); end
    wrst = 1'b0;
    model_ptr = 0;
    drive();
  endtask

  task automatic test_single_burst();
    int a0;
    begin_test();
    for (int j = 0; j < 3; j++) rq[0].push_back({(j == 2), DS'($urandom)});
    build_expected();
    drive();
    run_until_done(40, "single");
    n_cmp++; if (gnt_log[0] !== 4'b0000) begin n_err++; $display("FAIL single_gnt_pre: got %b required 0000", gnt_log[0]); end
    n_cmp++; if (gnt_log[1] !== 4'b0001) begin n_err++; $display("FAIL single_gnt_lat: got %b required 0001", gnt_log[1]); end
    n_cmp++; if (busy_log[1] !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b required 1", busy_log[1]); end
    for (int k = 1; k <= 3; k++) begin
      n_cmp++;
      if (winc_log[k] !== 1'b1) begin n_err++; $display("FAIL single_winc_c%0d: got %b required 1", k, winc_log[k]); end
    end
    n_cmp++; if (busy_log[4] !== 1'b0) begin n_err++; $display("FAIL single_busy_drop: got %b required 0", busy_log[4]); end
    n_cmp++; if (gid_log[4] !== 2'd0) begin n_err++; $display("FAIL single_gid: got %0d required 0", gid_log[4]); end
    a0 = 0;
    for (int k = 0; k < ack_log.size(); k++) if (ack_log[k][0] === 1'b1) a0++;
    n_cmp++; if (a0 !== 3) begin n_err++; $display("FAIL single_acks: got %0d required 3", a0); end
  endtask

  task automatic test_alternate();
    int want[4];
    want = '{0, 2, 0, 2};
    apply_reset();
    begin_test();
    for (int j = 0; j < 8; j++) begin
      rq[0].push_back({1'b0, DS'($urandom)});
      rq[2].push_back({1'b0, DS'($urandom)});
    end
    build_expected();
    drive();
    run_until_done(100, "alt");
    scan_bursts();
    n_cmp++; if (b_own.size() !== 4) begin n_err++; $display("FAIL alt_bursts: got %0d required 4", b_own.size()); end
    for (int b = 0; b < 4 && b < b_own.size(); b++) begin
      n_cmp++; if (b_own[b] !== want[b]) begin n_err++; $display("FAIL alt_owner_%0d: got %0d required %0d", b, b_own[b], want[b]); end
      n_cmp++; if (b_len[b] !== MAXB) begin n_err++; $display("FAIL alt_len_%0d: got %0d required %0d", b, b_len[b], MAXB); end
      if (b > 0) begin
        n_cmp++;
        if (b_st[b] - b_en[b-1] !== 3) begin n_err++; $display("FAIL alt_gap_%0d: got %0d required 3", b, b_st[b] - b_en[b-1]); end
      end
    end
  endtask

  task automatic test_wfull_stall();
    int w1;
    begin_test();
    for (int j = 0; j < 4; j++) rq[1].push_back({1'b0, DS'($urandom)});
    full_after = 2;
    build_expected();
    drive();
    run_until_done(60, "stall");
    scan_bursts();
    n_cmp++; if (wr_idx.size() !== 4) begin n_err++; $display("FAIL stall_writes: got %0d required 4", wr_idx.size()); end
    if (wr_idx.size() >= 3) begin
      w1 = wr_idx[1];
      for (int j = 1; j <= 5; j++) begin
        n_cmp++; if (gnt_log[w1+j] !== 4'b0010) begin n_err++; $display("FAIL stall_gnt_%0d: got %b required 0010", j, gnt_log[w1+j]); end
        n_cmp++; if (winc_log[w1+j] !== 1'b0) begin n_err++; $display("FAIL stall_winc_%0d: got %b required 0", j, winc_log[w1+j]); end
        n_cmp++; if (ack_log[w1+j] !== '0) begin n_err++; $display("FAIL stall_ack_%0d: got %b required 0", j, ack_log[w1+j]); end
      end
      n_cmp++; if (wr_idx[2] - w1 !== 6) begin n_err++; $display("FAIL stall_resume: got %0d required 6", wr_idx[2] - w1); end
    end
  endtask

  task automatic test_withdraw();
    int k;
    begin_test();
    rq[3].push_back({1'b0, DS'($urandom)});
    build_expected();
    drive();
    run_until_done(30, "withdraw");
    scan_bursts();
    n_cmp++; if (wr_idx.size() !== 1) begin n_err++; $display("FAIL wd_writes: got %0d required 1", wr_idx.size()); end
    if (wr_idx.size() >= 1) begin
      k = wr_idx[0];
      n_cmp++; if (gnt_log[k+1] !== 4'b1000) begin n_err++; $display("FAIL wd_hold: got %b required 1000", gnt_log[k+1]); end
      n_cmp++; if (winc_log[k+1] !== 1'b0) begin n_err++; $display("FAIL wd_nowrite: got %b required 0", winc_log[k+1]); end
      n_cmp++; if (gnt_log[k+2] !== 4'b0000) begin n_err++; $display("FAIL wd_release: got %b required 0000", gnt_log[k+2]); end
    end
    begin_test();
    rq[0].push_back({1'b1, DS'($urandom)});
    rq[3].push_back({1'b1, DS'($urandom)});
    build_expected();
    drive();
    run_until_done(30, "wd_next");
    scan_bursts();
    n_cmp++;
    if (b_own.size() < 1 || b_own[0] !== 0) begin
      n_err++; $display("FAIL wd_next_owner: got %0d required 0", (b_own.size() > 0) ? b_own[0] : -1);
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 30 && wr_cnt < 2; c++) step();
    n_cmp++; if (wr_cnt !== 2) begin n_err++; $display("FAIL mr_prefix: got %0d writes required 2", wr_cnt); end
    n_cmp++; if (winc !== 1'b1) begin n_err++; $display("FAIL mr_active: got winc %b required 1", winc); end
    #2;
    wrst = 1'b1;
    #1;
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL mr_gnt: got %b required 0", gnt); end
    n_cmp++; if (winc !== 1'b0) begin n_err++; $display("FAIL mr_winc: got %b required 0", winc); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mr_busy: got %b required 0", busy); end
    n_cmp++; if (ack !== '0) begin n_err++; $display("FAIL mr_ack: got %b required 0", ack); end
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
    req = '1;
    @(posedge wclk); #1;
    n_cmp++; if ((gnt | {3'b0, winc}) !== '0) begin n_err++; $display("FAIL mr_hold: gnt %b winc %b required 0", gnt, winc); end
    wrst = 1'b0;
    model_ptr = 0;
    begin_test();
    for (int i = 0; i < NREQ; i++) rq[i].push_back({1'b1, DS'($urandom)});
    build_expected();
    drive();
    run_until_done(60, "mr_after");
    scan_bursts();
    n_cmp++;
    if (b_own.size() < 1 || b_own[0] !== 0) begin
      n_err++; $display("FAIL mr_first_owner: got %0d required 0", (b_own.size() > 0) ? b_own[0] : -1);
    end
  endtask

  task automatic test_wrap_fairness();
    int want[5];
    want = '{0, 1, 2, 3, 0};
    begin_test();
    rq[0].push_back({1'b1, DS'($urandom)});
    rq[0].push_back({1'b1, DS'($urandom)});
    for (int i = 1; i < NREQ; i++) rq[i].push_back({1'b1, DS'($urandom)});
    build_expected();
    drive();
    run_until_done(60, "wrap");
    scan_bursts();
    n_cmp++; if (b_own.size() !== 5) begin n_err++; $display("FAIL wrap_bursts: got %0d required 5", b_own.size()); end
    for (int b = 0; b < 5 && b < b_own.size(); b++) begin
      n_cmp++; if (b_own[b] !== want[b]) begin n_err++; $display("FAIL wrap_owner_%0d: got %0d required %0d", b, b_own[b], want[b]); end
      n_cmp++; if (b_len[b] !== 1) begin n_err++; $display("FAIL wrap_len_%0d: got %0d required 1", b, b_len[b]); end
    end
  endtask

  task automatic test_random();
    int total;
    for (int r = 0; r < 4; r++) begin
      begin_test();
      rand_full = 1'b1;
      total = 0;
      for (int i = 0; i < NREQ; i++) begin
        int n;
        n = $urandom_range(0, 10);
        for (int j = 0; j < n; j++) rq[i].push_back({($urandom_range(0, 3) == 0), DS'($urandom)});
        total += n;
      end
      build_expected();
      drive();
      run_until_done(800, "rand");
      n_cmp++; if (wr_cnt !== total) begin n_err++; $display("FAIL rand_total_%0d: got %0d required %0d", r, wr_cnt, total); end
    end
  endtask

  initial begin
    wrst = 1'b1;
    req = '0; req_last = '0; req_data = '0; wfull = 1'b0;
    force_full = 0; rand_full = 1'b0; model_ptr = 0; wr_cnt = 0; full_after = 0;
    test_reset();
    test_single_burst();
    test_alternate();
    test_wfull_stall();
    test_withdraw();
    begin_test();
    for (int j = 0; j < 4; j++) rq[2].push_back({1'b0, DS'($urandom)});
    build_expected();
    drive();
    test_mid_reset();
    test_wrap_fairness();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of the async FIFO (fifo1) among NREQ requesters in the wclk domain.
- Grants one requester at a time for a bounded burst.
- Drives winc/wdata into the FIFO and stalls on wfull.
- Returns per-word acks to the owning requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATASIZE, 8, word width; matches the FIFO DATASIZE.
- MAXBURST, 4, maximum words per grant before forced release (1..15).

Ports:
- wclk  input  1  write-domain clock; all logic on rising edge.
- wrst  input  1  asynchronous active-high reset.
- req  input  NREQ  per-requester request; level, held while the requester has data.
- req_data  input  NREQ*DATASIZE  packed words; slice i belongs to requester i.
- req_last  input  NREQ  marks the current word of requester i as its last word.
- wfull  input  1  FIFO full flag (wclk domain).
- gnt  output  NREQ  one-hot grant, registered.
- ack  output  NREQ  word of requester i accepted this cycle; combinational.
- winc  output  1  FIFO write enable; combinational.
- wdata  output  DATASIZE  FIFO write data; mux of req_data by owner.
- grant_id  output  $clog2(NREQ)  index of current or last owner, registered.
- busy  output  1  high in GRANT state, registered.

Behaviour:
- Reset (wrst high, asynchronous): state=IDLE, gnt=0, busy=0, grant_id=0, burst count=0.
  - Round-robin pointer is set so requester 0 has highest priority first.
  - winc=0 and ack=0 while in reset. Release is synchronous to the next wclk edge.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - At an edge with req!=0, select the first set bit searching from (pointer) upward, wrapping modulo NREQ.
  - Load gnt and grant_id, clear burst count, go to GRANT.
  - With req==0, stay in IDLE.
- GRANT:
  - winc = req[grant_id] & !wfull.
  - ack[grant_id] = winc; all other ack bits are 0.
  - wdata = req_data slice grant_id in every cycle; the value is irrelevant when winc=0.
  - Each edge with winc=1 increments the burst count.
- Leave GRANT for RELEASE at the edge where any of these holds:
  - (a) winc & req_last[grant_id];
  - (b) winc and the incremented count == MAXBURST;
  - (c) req[grant_id]==0 (requester withdrew; no write that cycle).
- On entering RELEASE: gnt=0, busy=0, pointer=grant_id+1 mod NREQ.
- RELEASE: lasts one cycle, always goes to IDLE. Arbitration resumes in IDLE at the next edge.
  - This gives a fixed 2-cycle bubble between bursts and guarantees fairness.
- Latency:
  - If req is high before edge E, gnt and busy are high after E.
  - The first winc can assert in the cycle after E; the word is written at edge E+1.
  - Back-to-back accepted words are 1 per cycle while !wfull.
- wfull:
  - While wfull=1 in GRANT: winc=0 and ack=0, grant is held, and the burst count does not change.
  - There is no timeout; the grant is held indefinitely.
- Simultaneous events:
  - req_last with count reaching MAXBURST on the same word is a single release.
  - If req drops while wfull=1, condition (c) applies and the requester is released.
- Requesters must hold req_data and req_last stable until acked. The arbiter does not check this.
- Invariants:
  - gnt is zero or one-hot.
  - winc implies busy.
  - A non-owner never receives ack.
- Mid-burst reset: all outputs return to reset values immediately (asynchronously).
  - Any partially delivered burst is abandoned; no winc is issued after wrst rises.

Test Plan:
1. After reset, req=4'b0001 with req_last on the 3rd word, wfull=0 -> gnt=0001 one cycle after req; words D0,D1,D2 written on 3 consecutive edges; ack[0] pulses 3 times; busy drops after the 3rd word; grant_id=0.
2. req=4'b0101 held continuously, never last, MAXBURST=4 -> grants alternate 0,2,0,2; exactly 4 writes per grant; 2-cycle gap between bursts; ack never asserts for a non-owner.
3. Requester 1 granted, wfull forced high for 5 cycles after its 2nd word -> winc=0 and ack=0 for those 5 cycles; gnt stays 0010; writes resume when wfull drops; total writes=4.
4. Requester 3 granted and drops req after 1 word -> release without further winc; pointer=0; next req=4'b1001 grants requester 0 first.
5. Reset mid-burst: wrst pulsed while requester 2 holds grant with 2 of 4 words written -> gnt=0, winc=0, busy=0 immediately; after release, req=4'b1111 grants requester 0.
6. All four requesters active with req_last on every word -> grant order 0,1,2,3,0; one word each; fairness held across wrap-around.
